// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with double-buffered frame, dead-time, blanking and LZ suppression.
// Outputs registered (1-cycle latency from scan state); free-running scan, no backpressure, load is a fire-and-forget strobe.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank_en,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start,
  output logic                    load_pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // XOR masks: applying them converts lit-polarity (1 = lit) to pin polarity.
  localparam logic [6:0]            SEG_DARK = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_DARK  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] dig;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz;
  } frame_t;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  frame_t                shadow;
  frame_t                active;
  frame_t                in_frame;
  logic                  pending;
  logic                  last_cnt;
  logic                  last_idx;
  logic                  commit;
  logic                  in_dead;
  logic [NUM_DIGITS-1:0] lz_supp;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;
  logic [NUM_DIGITS-1:0] an_sel;

  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_lut = 7'b1111110;
      4'h1:    seg_lut = 7'b0110000;
      4'h2:    seg_lut = 7'b1101101;
      4'h3:    seg_lut = 7'b1111001;
      4'h4:    seg_lut = 7'b0110011;
      4'h5:    seg_lut = 7'b1011011;
      4'h6:    seg_lut = 7'b1011111;
      4'h7:    seg_lut = 7'b1110000;
      4'h8:    seg_lut = 7'b1111111;
      4'h9:    seg_lut = 7'b1111011;
      4'hA:    seg_lut = 7'b1110111;
      4'hB:    seg_lut = 7'b0011111;
      4'hC:    seg_lut = 7'b1001110;
      4'hD:    seg_lut = 7'b0111101;
      4'hE:    seg_lut = 7'b1001111;
      default: seg_lut = 7'b1000111;
    endcase
  endfunction

  assign in_frame     = {digits_in, dp_in, blank_in, lz_blank_en};
  assign last_cnt     = (int'(cnt) == REFRESH_DIV - 1);
  assign last_idx     = (int'(idx) == NUM_DIGITS - 1);
  assign commit       = last_cnt && last_idx && (pending || load);
  assign in_dead      = (int'(cnt) < DEAD_CYCLES);
  assign load_pending = pending;

  // Suppression runs from the most significant digit down and stops at the first non-zero nibble.
  always_comb begin
    logic run;
    run     = active.lz;
    lz_supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run && (active.dig[4*i +: 4] == 4'h0);
      if (i != 0) lz_supp[i] = run;
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    an_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx) == i) begin
        cur_nib   = active.dig[4*i +: 4];
        cur_dp    = active.dp[i] && !active.blank[i];
        cur_dark  = active.blank[i] || lz_supp[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      seg_out     <= SEG_DARK;
      dp_out      <= DP_DARK;
      an_out      <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      if (in_dead) begin
        seg_out <= SEG_DARK;
        dp_out  <= DP_DARK;
        an_out  <= AN_OFF;
      end else begin
        seg_out <= cur_dark ? SEG_DARK : (seg_lut(cur_nib) ^ SEG_DARK);
        dp_out  <= cur_dp ^ DP_DARK;
        an_out  <= an_sel ^ AN_OFF;
      end

      if (load) shadow <= in_frame;
      // A load landing on the wrap cycle bypasses the shadow so it is not held back a whole frame.
      if (commit) begin
        active  <= load ? in_frame : shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
      frame_start <= commit;

      if (last_cnt) begin
        cnt <= '0;
        idx <= last_idx ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
